// File: rtl/text_console_writer_if.sv
`default_nettype none
// ============================================================================
// Module   : text_console_writer_if
// Purpose  : Bundle of the text console writer's byte-input handshake, the
//            foreground colour, the VRAM write port and the cursor/status
//            outputs.
// Modports : master - byte source / VRAM observer
//                     (drives in_valid, in_data, fg_*)
//            slave  - the console writer
//                     (drives in_ready, vram_*, cursor_*, busy)
// Signals  : in_valid/in_ready/in_data  byte stream handshake
//            fg_r/fg_g/fg_b             foreground colour, sampled on accept
//            vram_we/vram_addr/vram_wdata  VRAM CPU-side write port
//            cursor_col/cursor_row      current cursor position
//            busy                       multi-cycle operation in progress
// Revision : 1.0 - initial release
// ============================================================================
interface text_console_writer_if #(
  parameter int COLS       = 80,
  parameter int ROWS       = 60,
  parameter int ADDR_WIDTH = $clog2(COLS * ROWS * 4)
);
  logic                  in_valid;
  logic                  in_ready;
  logic [7:0]            in_data;
  logic [7:0]            fg_r;
  logic [7:0]            fg_g;
  logic [7:0]            fg_b;
  logic                  vram_we;
  logic [ADDR_WIDTH-1:0] vram_addr;
  logic [7:0]            vram_wdata;
  logic [6:0]            cursor_col;
  logic [5:0]            cursor_row;
  logic                  busy;

  modport master (
    output in_valid, in_data, fg_r, fg_g, fg_b,
    input  in_ready, vram_we, vram_addr, vram_wdata, cursor_col, cursor_row, busy
  );

  modport slave (
    input  in_valid, in_data, fg_r, fg_g, fg_b,
    output in_ready, vram_we, vram_addr, vram_wdata, cursor_col, cursor_row, busy
  );
endinterface
`default_nettype wire

// File: rtl/text_console_writer.sv
`default_nettype none
// ============================================================================
// Module   : text_console_writer
// Purpose  : Byte-stream terminal front end. Accepts ASCII bytes, keeps a
//            cursor and writes glyphs plus foreground colour into the text
//            VRAM (planes char/R/G/B, addr = plane*CELLS + row*COLS + col).
//            Handles CR, LF, BS and FF (clear screen). Single clock domain.
// Ports    : cpu_clk - sole clock
//            rst     - synchronous, active-high reset
//            bus     - text_console_writer_if.slave (byte input, colour,
//                      VRAM write port, cursor and busy outputs)
// Options  : CONSOLE_CLEAR_LINE_EN - when defined, every row change (LF or
//            wrap at the last column) blanks the new row in all four planes
//            (CLR_LINE state, 4*COLS writes) before accepting more input.
// Revision : 1.0 - initial release
// ============================================================================
module text_console_writer #(
  parameter int COLS       = 80,
  parameter int ROWS       = 60,
  parameter int CELLS      = COLS * ROWS,
  parameter int ADDR_WIDTH = $clog2(CELLS * 4)
) (
  input  wire logic            cpu_clk,
  input  wire logic            rst,
  text_console_writer_if.slave bus
);

  localparam logic [7:0] CH_BS    = 8'h08;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_FF    = 8'h0C;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_TILDE = 8'h7E;

  localparam logic [6:0]            LAST_COL     = 7'(COLS - 1);
  localparam logic [5:0]            LAST_ROW     = 6'(ROWS - 1);
  localparam logic [ADDR_WIDTH-1:0] PLANE_STRIDE = ADDR_WIDTH'(CELLS);
  localparam logic [ADDR_WIDTH-1:0] CLEAR_LAST   = ADDR_WIDTH'(CELLS - 1);
`ifdef CONSOLE_CLEAR_LINE_EN
  localparam logic [ADDR_WIDTH-1:0] LINE_LAST    = ADDR_WIDTH'(COLS - 1);
`endif

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WR_CH = 3'd1,
    S_WR_R  = 3'd2,
    S_WR_G  = 3'd3,
    S_WR_B  = 3'd4,
    S_CLEAR = 3'd5
`ifdef CONSOLE_CLEAR_LINE_EN
    , S_CLR_LINE = 3'd6
`endif
  } state_t;

  state_t                state;
  logic                  in_ready;
  logic                  busy;
  logic                  vram_we;
  logic [ADDR_WIDTH-1:0] vram_addr;
  logic [7:0]            vram_wdata;
  logic [6:0]            cur_col;
  logic [5:0]            cur_row;
  logic [7:0]            fg_r_cap;
  logic [7:0]            fg_g_cap;
  logic [7:0]            fg_b_cap;

  // Fill engine shared by screen clear and line clear: walks fill_idx over
  // 0..fill_last inside each plane, starting each plane at
  // plane*CELLS + fill_base.
  logic [1:0]            plane;
  logic [ADDR_WIDTH-1:0] fill_idx;
  logic [ADDR_WIDTH-1:0] fill_last;
  logic [ADDR_WIDTH-1:0] fill_base;

  logic                  accept;
  logic                  printable;
  logic [5:0]            row_after;
  logic [ADDR_WIDTH-1:0] cell_addr;
  logic [1:0]            plane_next;
  logic [ADDR_WIDTH-1:0] next_plane_start;
  logic [7:0]            fill_data_cur;
  logic [7:0]            fill_data_next;

  function automatic logic [ADDR_WIDTH-1:0] row_base(input logic [5:0] r);
    return ADDR_WIDTH'(r) * ADDR_WIDTH'(COLS);
  endfunction

  // Blank-cell content per plane: space glyph, then the captured colour.
  function automatic logic [7:0] plane_fill(input logic [1:0] p,
                                            input logic [7:0] r,
                                            input logic [7:0] g,
                                            input logic [7:0] b);
    case (p)
      2'd0:    return CH_SPACE;
      2'd1:    return r;
      2'd2:    return g;
      default: return b;
    endcase
  endfunction

  always_comb begin
    accept           = bus.in_valid && in_ready;
    printable        = (bus.in_data >= CH_SPACE) && (bus.in_data <= CH_TILDE);
    row_after        = (cur_row == LAST_ROW) ? 6'd0 : cur_row + 6'd1;
    cell_addr        = row_base(cur_row) + ADDR_WIDTH'(cur_col);
    plane_next       = plane + 2'd1;
    next_plane_start = ADDR_WIDTH'(plane_next) * PLANE_STRIDE + fill_base;
    fill_data_cur    = plane_fill(plane, fg_r_cap, fg_g_cap, fg_b_cap);
    fill_data_next   = plane_fill(plane_next, fg_r_cap, fg_g_cap, fg_b_cap);
  end

  always_ff @(posedge cpu_clk) begin
    if (rst) begin
      state      <= S_IDLE;
      in_ready   <= 1'b0;
      busy       <= 1'b0;
      vram_we    <= 1'b0;
      vram_addr  <= '0;
      vram_wdata <= '0;
      cur_col    <= '0;
      cur_row    <= '0;
      fg_r_cap   <= '0;
      fg_g_cap   <= '0;
      fg_b_cap   <= '0;
      plane      <= '0;
      fill_idx   <= '0;
      fill_last  <= '0;
      fill_base  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          in_ready <= 1'b1;
          busy     <= 1'b0;
          vram_we  <= 1'b0;
          if (accept) begin
            fg_r_cap <= bus.fg_r;
            fg_g_cap <= bus.fg_g;
            fg_b_cap <= bus.fg_b;
            if (printable) begin
              // Glyph goes out on the first write cycle straight from the
              // accepted byte; the colour planes follow from the captures.
              state      <= S_WR_CH;
              in_ready   <= 1'b0;
              busy       <= 1'b1;
              vram_we    <= 1'b1;
              vram_addr  <= cell_addr;
              vram_wdata <= bus.in_data;
            end else begin
              case (bus.in_data)
                CH_CR: cur_col <= '0;
                CH_LF: begin
                  cur_row <= row_after;
`ifdef CONSOLE_CLEAR_LINE_EN
                  state      <= S_CLR_LINE;
                  in_ready   <= 1'b0;
                  busy       <= 1'b1;
                  vram_we    <= 1'b1;
                  vram_addr  <= row_base(row_after);
                  vram_wdata <= CH_SPACE;
                  plane      <= 2'd0;
                  fill_idx   <= '0;
                  fill_last  <= LINE_LAST;
                  fill_base  <= row_base(row_after);
`endif
                end
                CH_BS: begin
                  if (cur_col != 7'd0) cur_col <= cur_col - 7'd1;
                end
                CH_FF: begin
                  cur_col    <= '0;
                  cur_row    <= '0;
                  state      <= S_CLEAR;
                  in_ready   <= 1'b0;
                  busy       <= 1'b1;
                  vram_we    <= 1'b1;
                  vram_addr  <= '0;
                  vram_wdata <= CH_SPACE;
                  plane      <= 2'd0;
                  fill_idx   <= '0;
                  fill_last  <= CLEAR_LAST;
                  fill_base  <= '0;
                end
                default: ; // consumed and ignored
              endcase
            end
          end
        end

        S_WR_CH: begin
          state      <= S_WR_R;
          vram_addr  <= vram_addr + PLANE_STRIDE;
          vram_wdata <= fg_r_cap;
        end

        S_WR_R: begin
          state      <= S_WR_G;
          vram_addr  <= vram_addr + PLANE_STRIDE;
          vram_wdata <= fg_g_cap;
        end

        S_WR_G: begin
          state      <= S_WR_B;
          vram_addr  <= vram_addr + PLANE_STRIDE;
          vram_wdata <= fg_b_cap;
        end

        S_WR_B: begin
          if (cur_col == LAST_COL) begin
            cur_col <= '0;
            cur_row <= row_after;
`ifdef CONSOLE_CLEAR_LINE_EN
            state      <= S_CLR_LINE;
            vram_we    <= 1'b1;
            vram_addr  <= row_base(row_after);
            vram_wdata <= CH_SPACE;
            plane      <= 2'd0;
            fill_idx   <= '0;
            fill_last  <= LINE_LAST;
            fill_base  <= row_base(row_after);
`else
            state    <= S_IDLE;
            vram_we  <= 1'b0;
            in_ready <= 1'b1;
            busy     <= 1'b0;
`endif
          end else begin
            cur_col  <= cur_col + 7'd1;
            state    <= S_IDLE;
            vram_we  <= 1'b0;
            in_ready <= 1'b1;
            busy     <= 1'b0;
          end
        end

        S_CLEAR
`ifdef CONSOLE_CLEAR_LINE_EN
        , S_CLR_LINE
`endif
        : begin
          if (fill_idx == fill_last) begin
            if (plane == 2'd3) begin
              state    <= S_IDLE;
              vram_we  <= 1'b0;
              in_ready <= 1'b1;
              busy     <= 1'b0;
            end else begin
              // Jump to the same region in the next plane.
              plane      <= plane_next;
              fill_idx   <= '0;
              vram_addr  <= next_plane_start;
              vram_wdata <= fill_data_next;
            end
          end else begin
            fill_idx   <= fill_idx + ADDR_WIDTH'(1);
            vram_addr  <= vram_addr + ADDR_WIDTH'(1);
            vram_wdata <= fill_data_cur;
          end
        end

        default: begin
          state    <= S_IDLE;
          vram_we  <= 1'b0;
          in_ready <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.busy       = busy;
  assign bus.vram_we    = vram_we;
  assign bus.vram_addr  = vram_addr;
  assign bus.vram_wdata = vram_wdata;
  assign bus.cursor_col = cur_col;
  assign bus.cursor_row = cur_row;

endmodule
`default_nettype wire

// File: tb/tb_text_console_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_text_console_writer
// Purpose  : Self-checking bench for text_console_writer. Random byte and
//            colour stimulus is checked against a behavioural model that
//            tracks the cursor as a linear cell index and lists the expected
//            VRAM writes (addr = plane*CELLS + cell).
// Revision : 1.0 - initial release
// ============================================================================
module tb_text_console_writer;

  localparam int COLS   = 80;
  localparam int ROWS   = 60;
  localparam int CELLS  = COLS * ROWS;
  localparam int BUDGET = 30000;

  logic cpu_clk = 1'b0;
  logic rst     = 1'b1;

  text_console_writer_if #(.COLS(COLS), .ROWS(ROWS)) bus();

  text_console_writer #(.COLS(COLS), .ROWS(ROWS)) dut (
    .cpu_clk (cpu_clk),
    .rst     (rst),
    .bus     (bus)
  );

  always #5 cpu_clk = ~cpu_clk;

  typedef struct {
    int cyc;
    int addr;
    int data;
  } wr_t;

  wr_t wr_q[$];
  wr_t exp_q[$];
  int  cyc      = 0;
  int  busy_cnt = 0;
  int  n_checks = 0;
  int  n_fail   = 0;
  int  m_col    = 0;
  int  m_row    = 0;

  always @(posedge cpu_clk) cyc <= cyc + 1;

  // Write / busy monitor, sampled mid-cycle.
  always @(negedge cpu_clk) begin
    if (bus.vram_we === 1'b1)
      wr_q.push_back('{cyc, int'(bus.vram_addr), int'(bus.vram_wdata)});
    if (bus.busy === 1'b1) busy_cnt++;
  end

  // ---------------- reference model ----------------
  function automatic void model_byte(input int d, input int r, input int g, input int b);
    int lin;
    int pd[4];
    if (d >= 'h20 && d <= 'h7E) begin
      lin = m_row * COLS + m_col;
      pd[0] = d; pd[1] = r; pd[2] = g; pd[3] = b;
      for (int p = 0; p < 4; p++) exp_q.push_back('{0, p * CELLS + lin, pd[p]});
      lin   = (lin + 1) % CELLS;
      m_col = lin % COLS;
      m_row = lin / COLS;
    end else if (d == 'h0D) begin
      m_col = 0;
    end else if (d == 'h0A) begin
      m_row = (m_row + 1) % ROWS;
    end else if (d == 'h08) begin
      if (m_col > 0) m_col--;
    end else if (d == 'h0C) begin
      for (int i = 0; i < 4 * CELLS; i++)
        exp_q.push_back('{0, i, (i < CELLS) ? 'h20 : (i < 2 * CELLS) ? r : (i < 3 * CELLS) ? g : b});
      m_col = 0;
      m_row = 0;
    end
  endfunction

  function automatic int first_diff();
    int n = (wr_q.size() < exp_q.size()) ? wr_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      if (wr_q[i].addr != exp_q[i].addr || wr_q[i].data != exp_q[i].data) return i;
    if (wr_q.size() != exp_q.size()) return n;
    return -1;
  endfunction

  function automatic int gap_count();
    int g = 0;
    for (int i = 1; i < wr_q.size(); i++)
      if (wr_q[i].cyc != wr_q[i-1].cyc + 1) g++;
    return g;
  endfunction

  function automatic string diff_str(input int i);
    int aa = -1, ad = -1, ea = -1, ed = -1;
    if (i >= 0 && i < wr_q.size())  begin aa = wr_q[i].addr;  ad = wr_q[i].data;  end
    if (i >= 0 && i < exp_q.size()) begin ea = exp_q[i].addr; ed = exp_q[i].data; end
    return $sformatf("write #%0d got addr=%0d data=0x%0h (%0d writes) expected addr=%0d data=0x%0h (%0d writes)",
                     i, aa, ad, wr_q.size(), ea, ed, exp_q.size());
  endfunction

  function automatic int rand_byte();
    int k = $urandom_range(0, 9);
    int d;
    if (k <= 5) return $urandom_range(32, 126);
    if (k == 6) return 'h0D;
    if (k == 7) return 'h0A;
    if (k == 8) return 'h08;
    do d = $urandom_range(0, 255);
    while ((d >= 32 && d <= 126) || d == 'h08 || d == 'h0A || d == 'h0C || d == 'h0D);
    return d;
  endfunction

  // ---------------- stimulus helpers (called at a negedge) ----------------
  task automatic send_byte(input int d, input int r, input int g, input int b);
    int n = 0;
    while (bus.in_ready !== 1'b1 && n < BUDGET) begin @(negedge cpu_clk); n++; end
    if (n >= BUDGET) begin
      n_fail++;
      $display("FAIL send_timeout: in_ready=%b after %0d cycles, required 1", bus.in_ready, n);
    end
    bus.in_valid = 1'b1;
    bus.in_data  = d[7:0];
    bus.fg_r     = r[7:0];
    bus.fg_g     = g[7:0];
    bus.fg_b     = b[7:0];
    @(negedge cpu_clk);
    bus.in_valid = 1'b0;
    model_byte(d, r, g, b);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(bus.in_ready === 1'b1 && bus.busy === 1'b0) && n < BUDGET) begin
      @(negedge cpu_clk); n++;
    end
    if (n >= BUDGET) begin
      n_fail++;
      $display("FAIL idle_timeout: in_ready=%b busy=%b after %0d cycles, required 1/0", bus.in_ready, bus.busy, n);
    end
  endtask

  task automatic send_rand_printable();
    send_byte($urandom_range(32, 126), $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
    wait_idle();
  endtask

  task automatic goto_row(input int target);
    send_byte('h0D, 0, 0, 0);
    while (m_row != target) send_byte('h0A, 0, 0, 0);
    wait_idle();
  endtask

  task automatic clear_logs();
    wr_q.delete();
    exp_q.delete();
    busy_cnt = 0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data = '0; bus.fg_r = '0; bus.fg_g = '0; bus.fg_b = '0;
    repeat (3) @(negedge cpu_clk);
    n_checks++;
    if (bus.in_ready !== 1'b0 || bus.vram_we !== 1'b0 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: in_ready=%b vram_we=%b busy=%b, required 0/0/0", bus.in_ready, bus.vram_we, bus.busy);
    end
    n_checks++;
    if (bus.vram_addr !== '0 || bus.vram_wdata !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_vram: addr=%0d wdata=0x%0h, required 0/0x0", bus.vram_addr, bus.vram_wdata);
    end
    n_checks++;
    if (bus.cursor_col !== 7'd0 || bus.cursor_row !== 6'd0) begin
      n_fail++;
      $display("FAIL reset_cursor: (%0d,%0d), required (0,0)", bus.cursor_col, bus.cursor_row);
    end
    rst = 1'b0;
    @(negedge cpu_clk);
    n_checks++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_ready: in_ready=%b one cycle after rst drops, required 1", bus.in_ready);
    end
    m_col = 0; m_row = 0;
    clear_logs();
  endtask

  task automatic test_first_char();
    int acc, rdy, n, idx;
    clear_logs();
    send_byte('h41, 'hFF, 'h80, 'h00);
    acc = cyc;
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 50) begin @(negedge cpu_clk); n++; end
    rdy = cyc;
    wait_idle();
    n_checks++;
    if (rdy != acc + 4) begin
      n_fail++;
      $display("FAIL first_char_ready: in_ready back %0d cycles after accept, required 5", rdy - acc + 1);
    end
    idx = first_diff();
    n_checks++;
    if (idx != -1) begin
      n_fail++;
      $display("FAIL first_char_writes: %s", diff_str(idx));
    end
    n_checks++;
    if (wr_q.size() == 0 || wr_q[0].cyc != acc || gap_count() != 0) begin
      n_fail++;
      $display("FAIL first_char_timing: first write cycle %0d gaps %0d, required cycle %0d gaps 0",
               (wr_q.size() > 0) ? wr_q[0].cyc - acc : -1, gap_count(), 0);
    end
    n_checks++;
    if (busy_cnt != 4) begin
      n_fail++;
      $display("FAIL first_char_busy: busy cycles %0d, required 4", busy_cnt);
    end
    n_checks++;
    if (bus.cursor_col !== 7'd1 || bus.cursor_row !== 6'd0) begin
      n_fail++;
      $display("FAIL first_char_cursor: (%0d,%0d), required (1,0)", bus.cursor_col, bus.cursor_row);
    end
  endtask

  task automatic test_random_mix();
    int idx, bad = 0;
    clear_logs();
    for (int i = 0; i < 60; i++) begin
      send_byte(rand_byte(), $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
      wait_idle();
      n_checks++;
      if (bus.cursor_col !== 7'(m_col) || bus.cursor_row !== 6'(m_row)) begin
        n_fail++; bad++;
        if (bad <= 5)
          $display("FAIL mix_cursor: byte %0d cursor (%0d,%0d), required (%0d,%0d)",
                   i, bus.cursor_col, bus.cursor_row, m_col, m_row);
      end
    end
    idx = first_diff();
    n_checks++;
    if (idx != -1) begin
      n_fail++;
      $display("FAIL mix_writes: %s", diff_str(idx));
    end
  endtask

  task automatic test_row_wrap();
    int idx;
    goto_row(2);
    for (int i = 0; i < COLS - 1; i++) send_rand_printable();
    clear_logs();
    send_byte('h42, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
    wait_idle();
    n_checks++;
    if (wr_q.size() == 0 || wr_q[0].addr != 239 || wr_q[0].data != 'h42) begin
      n_fail++;
      $display("FAIL row_wrap_addr: %s", diff_str(0));
    end
    idx = first_diff();
    n_checks++;
    if (idx != -1) begin
      n_fail++;
      $display("FAIL row_wrap_writes: %s", diff_str(idx));
    end
    n_checks++;
    if (bus.cursor_col !== 7'd0 || bus.cursor_row !== 6'd3) begin
      n_fail++;
      $display("FAIL row_wrap_cursor: (%0d,%0d), required (0,3)", bus.cursor_col, bus.cursor_row);
    end
  endtask

  task automatic test_screen_wrap();
    int idx;
    clear_logs();
    goto_row(ROWS - 1);
    n_checks++;
    if (wr_q.size() != 0) begin
      n_fail++;
      $display("FAIL lf_no_write: %0d writes during CR/LF, required 0", wr_q.size());
    end
    for (int i = 0; i < COLS - 1; i++) send_rand_printable();
    clear_logs();
    send_byte('h43, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
    wait_idle();
    n_checks++;
    if (wr_q.size() == 0 || wr_q[0].addr != 4799 || wr_q[0].data != 'h43) begin
      n_fail++;
      $display("FAIL screen_wrap_addr: %s", diff_str(0));
    end
    idx = first_diff();
    n_checks++;
    if (idx != -1) begin
      n_fail++;
      $display("FAIL screen_wrap_writes: %s", diff_str(idx));
    end
    n_checks++;
    if (bus.cursor_col !== 7'd0 || bus.cursor_row !== 6'd0) begin
      n_fail++;
      $display("FAIL screen_wrap_cursor: (%0d,%0d), required (0,0)", bus.cursor_col, bus.cursor_row);
    end
  endtask

  task automatic test_back_to_back();
    int exp_c[3];
    int exp_r[3];
    int seq[3];
    goto_row(10);
    for (int i = 0; i < 5; i++) send_rand_printable();
    clear_logs();
    seq[0] = 'h0D; seq[1] = 'h0A; seq[2] = 'h08;
    exp_c[0] = 0; exp_c[1] = 0; exp_c[2] = 0;
    exp_r[0] = 10; exp_r[1] = 11; exp_r[2] = 11;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.in_data = seq[i][7:0];
      @(negedge cpu_clk);
      model_byte(seq[i], 0, 0, 0);
      n_checks++;
      if (bus.cursor_col !== 7'(exp_c[i]) || bus.cursor_row !== 6'(exp_r[i]) ||
          bus.in_ready !== 1'b1 || bus.vram_we !== 1'b0) begin
        n_fail++;
        $display("FAIL b2b_step%0d: cursor (%0d,%0d) in_ready=%b vram_we=%b, required (%0d,%0d) 1 0",
                 i, bus.cursor_col, bus.cursor_row, bus.in_ready, bus.vram_we, exp_c[i], exp_r[i]);
      end
    end
    bus.in_valid = 1'b0;
    @(negedge cpu_clk);
    n_checks++;
    if (wr_q.size() != 0 || busy_cnt != 0) begin
      n_fail++;
      $display("FAIL b2b_quiet: %0d writes %0d busy cycles, required 0/0", wr_q.size(), busy_cnt);
    end
  endtask

  task automatic test_clear();
    int idx;
    int sa[5];
    int sd[5];
    send_rand_printable();
    clear_logs();
    send_byte('h0C, 'h11, 'h22, 'h33);
    wait_idle();
    n_checks++;
    if (busy_cnt != 4 * CELLS) begin
      n_fail++;
      $display("FAIL clear_busy: busy cycles %0d, required %0d", busy_cnt, 4 * CELLS);
    end
    idx = first_diff();
    n_checks++;
    if (idx != -1) begin
      n_fail++;
      $display("FAIL clear_writes: %s", diff_str(idx));
    end
    n_checks++;
    if (gap_count() != 0) begin
      n_fail++;
      $display("FAIL clear_consecutive: %0d gaps between writes, required 0", gap_count());
    end
    sa[0] = 0;     sd[0] = 'h20;
    sa[1] = 4799;  sd[1] = 'h20;
    sa[2] = 4800;  sd[2] = 'h11;
    sa[3] = 14399; sd[3] = 'h22;
    sa[4] = 19199; sd[4] = 'h33;
    for (int k = 0; k < 5; k++) begin
      n_checks++;
      if (wr_q.size() <= sa[k] || wr_q[sa[k]].addr != sa[k] || wr_q[sa[k]].data != sd[k]) begin
        n_fail++;
        $display("FAIL clear_spot%0d: got %s ; required addr=%0d data=0x%0h", k, diff_str(sa[k]), sa[k], sd[k]);
      end
    end
    n_checks++;
    if (bus.cursor_col !== 7'd0 || bus.cursor_row !== 6'd0) begin
      n_fail++;
      $display("FAIL clear_cursor: (%0d,%0d), required (0,0)", bus.cursor_col, bus.cursor_row);
    end
  endtask

  task automatic test_reset_mid_clear();
    int n = 0;
    int idx;
    send_rand_printable();
    send_rand_printable();
    clear_logs();
    send_byte('h0C, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
    while (wr_q.size() < 100 && n < 500) begin @(negedge cpu_clk); n++; end
    if (n >= 500) begin
      n_fail++;
      $display("FAIL abort_wait_timeout: %0d writes seen, required 100", wr_q.size());
    end
    rst = 1'b1;
    @(negedge cpu_clk);
    n_checks++;
    if (bus.vram_we !== 1'b0 || bus.busy !== 1'b0 || bus.in_ready !== 1'b0 ||
        bus.cursor_col !== 7'd0 || bus.cursor_row !== 6'd0) begin
      n_fail++;
      $display("FAIL abort_state: vram_we=%b busy=%b in_ready=%b cursor (%0d,%0d), required 0 0 0 (0,0)",
               bus.vram_we, bus.busy, bus.in_ready, bus.cursor_col, bus.cursor_row);
    end
    rst = 1'b0;
    @(negedge cpu_clk);
    n_checks++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_ready: in_ready=%b one cycle after rst drops, required 1", bus.in_ready);
    end
    m_col = 0; m_row = 0;
    clear_logs();
    send_byte('h41, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
    wait_idle();
    n_checks++;
    if (wr_q.size() == 0 || wr_q[0].addr != 0 || wr_q[0].data != 'h41) begin
      n_fail++;
      $display("FAIL abort_restart_addr: %s", diff_str(0));
    end
    idx = first_diff();
    n_checks++;
    if (idx != -1) begin
      n_fail++;
      $display("FAIL abort_restart_writes: %s", diff_str(idx));
    end
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.fg_r     = '0;
    bus.fg_g     = '0;
    bus.fg_b     = '0;
    @(negedge cpu_clk);
    test_reset();
    test_first_char();
    test_random_mix();
    test_row_wrap();
    test_screen_wrap();
    test_back_to_back();
    test_clear();
    test_reset_mid_clear();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/text_console_writer.md
Name: text_console_writer

Overview:
- Byte-stream terminal front end that drives the CPU-side write port of the text VRAM (char/R/G/B planes).
- Accepts ASCII bytes over valid/ready and maintains a cursor.
- Writes printable glyphs with the current foreground colour and handles CR, LF, BS and FF (clear screen).
- Sits upstream of the VRAM/display top and runs entirely in the cpu_clk domain.

Parameters:
- COLS, 80, text columns.
- ROWS, 60, text rows.
- CELLS, COLS*ROWS, cells per plane.
- ADDR_WIDTH, $clog2(CELLS*4), VRAM address width; matches the display top.

Ports:
- cpu_clk  in  1  sole clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input byte valid.
- in_ready  out  1  block can accept a byte.
- in_data  in  8  ASCII byte.
- fg_r  in  8  foreground red, sampled on accept.
- fg_g  in  8  foreground green, sampled on accept.
- fg_b  in  8  foreground blue, sampled on accept.
- vram_we  out  1  VRAM write strobe, one write per cycle.
- vram_addr  out  ADDR_WIDTH  VRAM address.
- vram_wdata  out  8  VRAM write data.
- cursor_col  out  7  current column.
- cursor_row  out  6  current row.
- busy  out  1  multi-cycle operation in progress.

Behaviour:
- Interface: one clock (cpu_clk); reset rst is synchronous and active-high.
- Reset values: in_ready=0 while rst=1, 1 from the first cycle after rst drops. vram_we=0, vram_addr=0, vram_wdata=0, cursor=(0,0), busy=0, state=IDLE.
- VRAM map:
  - addr = plane*CELLS + row*COLS + col.
  - Planes: 0=char, 1=R, 2=G, 3=B.
  - Address arithmetic at ADDR_WIDTH; no overflow possible for legal row/col.
- Accept occurs when in_valid && in_ready. in_ready=1 only in IDLE. in_data and fg_* are captured on the accept edge.
- States: IDLE, WR_CH, WR_R, WR_G, WR_B, CLEAR (plus CLR_LINE with the option).
- Printable byte (0x20..0x7E), accepted at cycle T:
  - WR_CH..WR_B occupy T+1..T+4, vram_we=1 in each.
  - Data written in order: byte, fg_r, fg_g, fg_b.
  - busy=1 T+1..T+4.
  - Cursor advances on the T+4 edge; in_ready=1 again at T+5.
- Advance rule: col+1. At col=COLS-1: col=0 and row+1. At row=ROWS-1 the row wraps to 0 (no scroll).
- CR 0x0D: col=0 on the accept edge. No stall, no VRAM write.
- LF 0x0A: row+1 (wrap ROWS-1 to 0) on the accept edge; col unchanged. No stall.
- BS 0x08: col-1 if col>0, else no change. No row change, no write, no stall.
- FF 0x0C:
  - Enter CLEAR and set cursor=(0,0).
  - Write 0x20 to char plane addresses 0..CELLS-1, then fg_r/fg_g/fg_b (colours captured at accept) to the R, G and B planes.
  - Writes are sequential addresses 0..4*CELLS-1, one per cycle.
  - busy=1 and in_ready=0 for exactly 4*CELLS cycles; return to IDLE.
- All other bytes (0x00-0x1F not listed above, 0x7F-0xFF): consumed and ignored, no stall.
- vram_we is deasserted in IDLE. vram_addr/vram_wdata hold their last value when idle.
- rst asserted mid-operation aborts the operation immediately. The partial write sequence is not completed; all outputs take reset values on the next edge.
- in_valid while in_ready=0: the byte is held by the source and is not lost.

Optional Feature:
- Macro CONSOLE_CLEAR_LINE_EN.
- Defined:
  - Any row change (LF, or wrap from the advance rule) enters CLR_LINE after the cursor update.
  - CLR_LINE writes 0x20 to the char plane and the captured fg colour to the R/G/B planes for all COLS cells of the new row: 4*COLS writes in plane order, busy=1, in_ready=0.
  - LF therefore stalls for 4*COLS cycles.
- Undefined: CLR_LINE is absent; LF and wrap never write VRAM.

Test Plan:
- Reset, then 'A' (0x41) with fg=FF/80/00 -> writes (0,0x41), (4800,0xFF), (9600,0x80), (14400,0x00) on 4 consecutive cycles. Cursor then (1,0); in_ready high 5 cycles after accept.
- Cursor at (79,2), send 'B' -> char write at addr 239, cursor becomes (0,3).
- Cursor at (79,59), send 'C' -> char write at addr 4799, cursor wraps to (0,0).
- Sequence CR, LF, BS:
  - From (5,10), send CR/LF/BS back-to-back -> cursor (0,10), then (0,11), then (0,11).
  - in_ready stays 1 throughout; no vram_we.
- FF with fg=11/22/33 -> 19200 consecutive writes.
  - addr 0 = 0x20, addr 4799 = 0x20, addr 4800 = 0x11, addr 14399 = 0x22, addr 19199 = 0x33.
  - busy high exactly 19200 cycles; cursor (0,0).
- FF, then assert rst at write 100 -> vram_we=0 next cycle and cursor (0,0). in_ready=1 one cycle after rst drops; a new 'A' writes addr 0.
